conv_result_writer: RTL and testbench

Write-back end of the conv datapath: accepts the 32-bit accumulator stream produced by one `pe`, requantizes each word to 8 bits (arithmetic shift, optional ReLU, unsigned saturation) and writes it into an 8-bit image memory. It fills a ROWS×COLS output map at a programmable base address and row pitch, so layer-1 results land in exactly the layout the next layer's `mem_reader` consumes. It is the write-side counterpart of `mem_reader`: one instance per PE output channel.

---
 rtl/conv_pkg.sv | 38 +++
 rtl/conv_result_writer_if.sv | 26 ++
 rtl/requant_sat_unit.sv | 19 +
 rtl/conv_result_writer.sv | 107 ++++++++++
 tb/tb_conv_result_writer.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared widths, writer FSM states and the requantize/saturate function
package conv_pkg;

    localparam int ACC_W = 32;
    localparam int PIX_W = 8;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_RUN  = 2'd1,
        WR_DONE = 2'd2
    } wr_state_t;

    typedef struct packed {
        logic [PIX_W-1:0] pix;
        logic             clamp;
    } requant_t;

    // ReLU zeroing is not a clamp; with relu off, negatives are clamps of the unsigned range.
    function automatic requant_t requant_sat(input logic signed [ACC_W-1:0] acc,
                                             input logic [4:0]              shift,
                                             input logic                    relu);
        logic signed [ACC_W-1:0] v;
        requant_t                r;
        v       = acc >>> shift;
        r.pix   = '0;
        r.clamp = 1'b0;
        if (v < 0) begin
            r.clamp = ~relu;
        end else if (v > 255) begin
            r.pix   = '1;
            r.clamp = 1'b1;
        end else begin
            r.pix = v[PIX_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/conv_result_writer_if.sv
// rtl/conv_result_writer_if.sv - accumulator input stream plus image-memory write port
interface conv_result_writer_if #(
    parameter int ADDR_W = 8
);
    logic                      start;
    logic [ADDR_W-1:0]         base;
    logic                      in_valid;
    logic [conv_pkg::ACC_W-1:0] in_data;
    logic                      in_ready;
    logic                      wr_en;
    logic [ADDR_W-1:0]         wr_addr;
    logic [conv_pkg::PIX_W-1:0] wr_data;
    logic                      busy;
    logic                      done;
    logic [15:0]               sat_cnt;

    modport master (
        output start, base, in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data, busy, done, sat_cnt
    );

    modport slave (
        input  start, base, in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data, busy, done, sat_cnt
    );
endinterface

// File: rtl/requant_sat_unit.sv
// rtl/requant_sat_unit.sv - combinational wrapper around requant_sat
module requant_sat_unit
    import conv_pkg::*;
#(
    parameter int SHIFT = 0,
    parameter int RELU  = 1
) (
    input  logic [ACC_W-1:0] acc_i,
    output logic [PIX_W-1:0] pix_o,
    output logic             clamp_o
);
    requant_t r;

    always_comb begin
        r       = requant_sat($signed(acc_i), 5'(SHIFT), 1'(RELU));
        pix_o   = r.pix;
        clamp_o = r.clamp;
    end
endmodule

// File: rtl/conv_result_writer.sv
// rtl/conv_result_writer.sv - requantizes a PE accumulator stream and rasters it into image memory
module conv_result_writer
    import conv_pkg::*;
#(
    parameter int ROWS   = 13,
    parameter int COLS   = 13,
    parameter int ADDR_W = 8,
    parameter int PITCH  = 13,
    parameter int SHIFT  = 0,
    parameter int RELU   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    conv_result_writer_if.slave  bus
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    wr_state_t         state_q, state_d;
    logic [RW-1:0]     row_q;
    logic [CW-1:0]     col_q;
    logic [ADDR_W-1:0] row_start_q;
    logic [15:0]       sat_cnt_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [PIX_W-1:0]  wr_data_q;
    logic              done_q;

    logic              hs;
    logic              last_col;
    logic              last_pix;
    logic [PIX_W-1:0]  rq_pix;
    logic              rq_clamp;

    requant_sat_unit #(.SHIFT(SHIFT), .RELU(RELU)) u_requant (
        .acc_i   (bus.in_data),
        .pix_o   (rq_pix),
        .clamp_o (rq_clamp)
    );

    assign hs       = bus.in_valid && (state_q == WR_RUN);
    assign last_col = (col_q == CW'(COLS - 1));
    assign last_pix = last_col && (row_q == RW'(ROWS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= WR_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WR_IDLE: if (bus.start)        state_d = WR_RUN;
            WR_RUN:  if (hs && last_pix)   state_d = WR_DONE;
            WR_DONE:                       state_d = WR_IDLE;
            default:                       state_d = WR_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready = (state_q == WR_RUN);
        bus.busy     = (state_q != WR_IDLE);
    end

    // Row-start register plus column offset replaces r*PITCH+c.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q       <= '0;
            col_q       <= '0;
            row_start_q <= '0;
            sat_cnt_q   <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            if (state_q == WR_IDLE && bus.start) begin
                row_start_q <= bus.base;
                row_q       <= '0;
                col_q       <= '0;
                sat_cnt_q   <= '0;
            end
            if (hs) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= row_start_q + ADDR_W'(col_q);
                wr_data_q <= rq_pix;
                done_q    <= last_pix;
                if (rq_clamp && sat_cnt_q != 16'hFFFF) sat_cnt_q <= sat_cnt_q + 16'd1;
                if (last_col) begin
                    col_q       <= '0;
                    row_q       <= row_q + RW'(1);
                    row_start_q <= row_start_q + ADDR_W'(PITCH);
                end else begin
                    col_q <= col_q + CW'(1);
                end
            end
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign bus.done    = done_q;
    assign bus.sat_cnt = sat_cnt_q;
endmodule

// File: tb/tb_conv_result_writer.sv
// tb/tb_conv_result_writer.sv - directed self-checking bench for conv_result_writer
module tb_conv_result_writer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    conv_result_writer_if #(.ADDR_W(8)) ia ();
    conv_result_writer_if #(.ADDR_W(8)) ib ();
    conv_result_writer_if #(.ADDR_W(8)) ic ();

    conv_result_writer #(.ROWS(2), .COLS(2), .ADDR_W(8), .PITCH(2), .SHIFT(0), .RELU(1))
        u_a (.clk(clk), .rst(rst), .bus(ia));
    conv_result_writer #(.ROWS(3), .COLS(3), .ADDR_W(8), .PITCH(16), .SHIFT(0), .RELU(1))
        u_b (.clk(clk), .rst(rst), .bus(ib));
    conv_result_writer #(.ROWS(2), .COLS(2), .ADDR_W(8), .PITCH(2), .SHIFT(4), .RELU(0))
        u_c (.clk(clk), .rst(rst), .bus(ic));

    logic [31:0] a_in  [4] = '{32'd5, 32'd300, 32'hFFFF_FFF9, 32'd255};
    logic [31:0] a_exp [4] = '{32'd5, 32'd255, 32'd0, 32'd255};
    logic [31:0] b_addr[9] = '{32'd0, 32'd1, 32'd2, 32'd16, 32'd17, 32'd18, 32'd32, 32'd33, 32'd34};
    logic [31:0] c_in  [4] = '{32'h0000_0FF0, 32'h0000_1000, 32'hFFFF_FFF0, 32'h0000_0010};
    logic [31:0] c_exp [4] = '{32'd255, 32'd255, 32'd0, 32'd1};
    logic [31:0] c_sat [4] = '{32'd0, 32'd1, 32'd2, 32'd2};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic        prev_v;
        logic [31:0] prev_d;
        int          nhs;
        int          nw;

        {ia.start, ia.in_valid, ia.base, ia.in_data} = '0;
        {ib.start, ib.in_valid, ib.base, ib.in_data} = '0;
        {ic.start, ic.in_valid, ic.base, ic.in_data} = '0;

        // reset values
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(ia.in_ready), 0);
        chk("rst_wr_en",    32'(ia.wr_en),    0);
        chk("rst_wr_addr",  32'(ia.wr_addr),  0);
        chk("rst_wr_data",  32'(ia.wr_data),  0);
        chk("rst_busy",     32'(ia.busy),     0);
        chk("rst_done",     32'(ia.done),     0);
        chk("rst_sat_cnt",  32'(ia.sat_cnt),  0);
        rst = 1'b0;

        // 2x2 frame at base 8, continuous valid; start pulsed during DONE
        @(negedge clk); ia.start = 1'b1; ia.base = 8'd8;
        @(negedge clk); ia.start = 1'b0;
        chk("a_ready_run", 32'(ia.in_ready), 1);
        chk("a_busy_run",  32'(ia.busy),     1);
        chk("a_no_wr",     32'(ia.wr_en),    0);
        ia.in_valid = 1'b1; ia.in_data = a_in[0];
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("a_wr_en",   32'(ia.wr_en),   1);
            chk("a_wr_addr", 32'(ia.wr_addr), 32'(8 + i));
            chk("a_wr_data", 32'(ia.wr_data), a_exp[i]);
            chk("a_done",    32'(ia.done),    (i == 3) ? 32'd1 : 32'd0);
            if (i < 3) ia.in_data = a_in[i+1];
            else begin
                chk("a_sat_cnt",   32'(ia.sat_cnt),  1);
                chk("a_busy_done", 32'(ia.busy),     1);
                chk("a_rdy_done",  32'(ia.in_ready), 0);
                ia.in_valid = 1'b0; ia.start = 1'b1; ia.base = 8'h40;
            end
        end
        @(negedge clk); ia.start = 1'b0;
        chk("a_idle_busy", 32'(ia.busy),    0);
        chk("a_idle_done", 32'(ia.done),    0);
        chk("a_idle_wr",   32'(ia.wr_en),   0);
        chk("a_sat_hold",  32'(ia.sat_cnt), 1);
        @(negedge clk);
        chk("a_done_start_ign", 32'(ia.busy), 0);

        // 3x3 frame with pitch 16; start pulsed mid-frame must not relatch
        @(negedge clk); ib.start = 1'b1; ib.base = 8'd0;
        @(negedge clk); ib.start = 1'b0; ib.in_valid = 1'b1; ib.in_data = 32'd0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("b_wr_en",   32'(ib.wr_en),   1);
            chk("b_wr_addr", 32'(ib.wr_addr), b_addr[i]);
            chk("b_wr_data", 32'(ib.wr_data), 32'(i));
            chk("b_done",    32'(ib.done),    (i == 8) ? 32'd1 : 32'd0);
            ib.start = (i == 3); ib.base = 8'h80;
            ib.in_data = 32'(i + 1);
            if (i == 8) ib.in_valid = 1'b0;
        end
        @(negedge clk); ib.start = 1'b0;
        chk("b_end_wr", 32'(ib.wr_en), 0);

        // shift 4, ReLU off: exact 255, clamp high, negative clamp, small value
        @(negedge clk); ic.start = 1'b1; ic.base = 8'd0;
        @(negedge clk); ic.start = 1'b0; ic.in_valid = 1'b1; ic.in_data = c_in[0];
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("c_wr_data", 32'(ic.wr_data), c_exp[i]);
            chk("c_sat_cnt", 32'(ic.sat_cnt), c_sat[i]);
            if (i < 3) ic.in_data = c_in[i+1];
            else ic.in_valid = 1'b0;
        end

        // in_valid toggling over a 2x2 frame at base 0x20
        @(negedge clk); ia.start = 1'b1; ia.base = 8'h20;
        prev_v = 1'b0; prev_d = '0; nhs = 0; nw = 0;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            ia.start = 1'b0;
            chk("d_wr_en",    32'(ia.wr_en),    32'(prev_v));
            chk("d_in_ready", 32'(ia.in_ready), (nhs < 4) ? 32'd1 : 32'd0);
            if (prev_v) begin
                chk("d_wr_addr", 32'(ia.wr_addr), 32'(8'h20 + nw));
                chk("d_wr_data", 32'(ia.wr_data), prev_d);
                nw++;
                chk("d_done", 32'(ia.done), (nw == 4) ? 32'd1 : 32'd0);
            end
            prev_v      = ((t % 2) == 0) && (nhs < 4);
            prev_d      = 32'(t);
            ia.in_valid = prev_v;
            ia.in_data  = prev_d;
            if (prev_v) nhs++;
        end
        chk("d_pulses", 32'(nw), 4);
        @(negedge clk);
        chk("d_end_wr", 32'(ia.wr_en), 0);

        // reset after 2 of 4 pixels, then restart at base 0
        @(negedge clk); ia.start = 1'b1; ia.base = 8'h30;
        @(negedge clk); ia.start = 1'b0; ia.in_valid = 1'b1; ia.in_data = 32'd1;
        @(negedge clk); ia.in_data = 32'd2;
        @(negedge clk);
        chk("e_pre_addr", 32'(ia.wr_addr), 32'h31);
        ia.in_valid = 1'b0; rst = 1'b1;
        #1;
        chk("e_rst_wr_en",   32'(ia.wr_en),    0);
        chk("e_rst_addr",    32'(ia.wr_addr),  0);
        chk("e_rst_data",    32'(ia.wr_data),  0);
        chk("e_rst_busy",    32'(ia.busy),     0);
        chk("e_rst_ready",   32'(ia.in_ready), 0);
        chk("e_rst_sat",     32'(ia.sat_cnt),  0);
        @(negedge clk); rst = 1'b0;
        chk("e_post_wr_en", 32'(ia.wr_en), 0);
        @(negedge clk); ia.start = 1'b1; ia.base = 8'd0;
        @(negedge clk); ia.start = 1'b0; ia.in_valid = 1'b1; ia.in_data = 32'd9;
        @(negedge clk);
        chk("e_restart_en",   32'(ia.wr_en),   1);
        chk("e_restart_addr", 32'(ia.wr_addr), 0);
        chk("e_restart_data", 32'(ia.wr_data), 9);
        ia.in_valid = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
